// File: rtl/mcntl_noc_tx.sv
// mcntl_noc_tx: transmit-side packetizer for the manager controller.
//
// Takes a header request (type, payload type, destination manager, word count)
// and a stream of data words, then frames those words as one NoC packet.
// Framing uses cntl: SOM=01, MOM=00, EOM=10, SOM_EOM=11.
//
// Data words are staged in a small FIFO. Writes into the FIFO are accepted in
// any FSM state. Words beyond the current packet length stay queued for the
// next packet.
//
// NoC back-pressure (noc__mcntl__ready) is registered once before use. After
// ready is dropped, the NoC still absorbs the word(s) already in flight.
//
// Optional build macro MCNTL_NOC_TX_LOCAL_DROP_EN: when defined, a packet
// addressed to this manager (req_mgrId == sys__mgr__mgrId) is silently drained
// from the FIFO instead of being sent, and it is not counted.
//
// Ports:
//   clk, reset_poweron_n            clock, asynchronous active-low reset
//   mcntl__tx__req_*                header request (valid/ready handshake)
//   mcntl__tx__data*                data-word stream into the FIFO
//   tx__mcntl__data_ready           FIFO not full
//   mcntl__noc__*                   registered NoC word outputs
//   noc__mcntl__ready               NoC can accept (used one cycle late)
//   sys__mgr__mgrId                 own manager ID
//   tx__mcntl__busy                 packet in progress
//   tx__mcntl__pkt_count            packets completed (wraps)
//   tx__mcntl__err_zero_len         one-cycle pulse on a zero-length request

`ifndef MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE
`define MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE 2:0
`endif
`ifndef MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE
`define MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE 1:0
`endif
`ifndef MGR_MGR_ID_RANGE
`define MGR_MGR_ID_RANGE 3:0
`endif
`ifndef MGR_NOC_CONT_INTERNAL_DATA_RANGE
`define MGR_NOC_CONT_INTERNAL_DATA_RANGE 31:0
`endif
`ifndef COMMON_STD_INTF_CNTL_RANGE
`define COMMON_STD_INTF_CNTL_RANGE 1:0
`endif

module mcntl_noc_tx #(
    parameter int DATA_FIFO_DEPTH = 4,
    parameter int MAX_PKT_WORDS   = 16,
    parameter int PKT_CNT_WIDTH   = 16,
    localparam int LEN_W = $clog2(MAX_PKT_WORDS) + 1,
    localparam int PTR_W = $clog2(DATA_FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                                        clk,
    input  logic                                        reset_poweron_n,
    input  logic                                        mcntl__tx__req_valid,
    input  logic [`MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE]  mcntl__tx__req_type,
    input  logic [`MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE] mcntl__tx__req_ptype,
    input  logic [`MGR_MGR_ID_RANGE]                    mcntl__tx__req_mgrId,
    input  logic [LEN_W-1:0]                            mcntl__tx__req_num_words,
    output logic                                        tx__mcntl__req_ready,
    input  logic                                        mcntl__tx__data_valid,
    input  logic [`MGR_NOC_CONT_INTERNAL_DATA_RANGE]    mcntl__tx__data,
    output logic                                        tx__mcntl__data_ready,
    output logic                                        mcntl__noc__valid,
    output logic [`COMMON_STD_INTF_CNTL_RANGE]          mcntl__noc__cntl,
    output logic [`MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE]  mcntl__noc__type,
    output logic [`MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE] mcntl__noc__ptype,
    output logic [`MGR_NOC_CONT_INTERNAL_DATA_RANGE]    mcntl__noc__data,
    output logic                                        mcntl__noc__pvalid,
    output logic [`MGR_MGR_ID_RANGE]                    mcntl__noc__mgrId,
    input  logic                                        noc__mcntl__ready,
    input  logic [`MGR_MGR_ID_RANGE]                    sys__mgr__mgrId,
    output logic                                        tx__mcntl__busy,
    output logic [PKT_CNT_WIDTH-1:0]                    tx__mcntl__pkt_count,
    output logic                                        tx__mcntl__err_zero_len
);

`ifdef MCNTL_NOC_TX_LOCAL_DROP_EN
    localparam logic LOCAL_DROP_EN = 1'b1;
`else
    localparam logic LOCAL_DROP_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(DATA_FIFO_DEPTH);
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_PKT_WORDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   ready_d1_q;

    // FIFO storage and bookkeeping
    logic [`MGR_NOC_CONT_INTERNAL_DATA_RANGE] mem_q [DATA_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s, fifo_empty_s;

    // Latched header of the packet in progress
    logic [`MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE]  hdr_type_q, hdr_type_d;
    logic [`MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE] hdr_ptype_q, hdr_ptype_d;
    logic [`MGR_MGR_ID_RANGE]                    hdr_mgr_q, hdr_mgr_d;
    logic [LEN_W-1:0]                            len_q, len_d;
    logic [LEN_W-1:0]                            rem_q, rem_d;
    logic                                        drop_q, drop_d;

    // Registered NoC outputs
    logic                                        valid_q, valid_d;
    logic [`COMMON_STD_INTF_CNTL_RANGE]          cntl_q, cntl_d;
    logic [`MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE]  type_q, type_d;
    logic [`MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE] ptype_q, ptype_d;
    logic [`MGR_NOC_CONT_INTERNAL_DATA_RANGE]    data_q, data_d;
    logic [`MGR_MGR_ID_RANGE]                    mgr_q, mgr_d;
    logic [PKT_CNT_WIDTH-1:0]                    pkt_count_q, pkt_count_d;
    logic                                        err_q, err_d;

    // Full is judged on the registered count, so a pop in the same cycle
    // never opens room for a push at full.
    assign tx__mcntl__data_ready = (count_q != FIFO_FULL);
    assign push_s                = mcntl__tx__data_valid & tx__mcntl__data_ready;
    assign fifo_empty_s          = (count_q == {CNT_W{1'b0}});

    assign tx__mcntl__req_ready    = (state_q == ST_IDLE);
    assign tx__mcntl__busy         = (state_q == ST_SEND);
    assign mcntl__noc__valid       = valid_q;
    assign mcntl__noc__pvalid      = valid_q;
    assign mcntl__noc__cntl        = cntl_q;
    assign mcntl__noc__type        = type_q;
    assign mcntl__noc__ptype       = ptype_q;
    assign mcntl__noc__data        = data_q;
    assign mcntl__noc__mgrId       = mgr_q;
    assign tx__mcntl__pkt_count    = pkt_count_q;
    assign tx__mcntl__err_zero_len = err_q;

    // FSM next state, header capture, word launch and output register values
    always_comb begin
        state_d     = state_q;
        hdr_type_d  = hdr_type_q;
        hdr_ptype_d = hdr_ptype_q;
        hdr_mgr_d   = hdr_mgr_q;
        len_d       = len_q;
        rem_d       = rem_q;
        drop_d      = drop_q;
        valid_d     = 1'b0;
        cntl_d      = cntl_q;
        type_d      = type_q;
        ptype_d     = ptype_q;
        data_d      = data_q;
        mgr_d       = mgr_q;
        pkt_count_d = pkt_count_q;
        err_d       = 1'b0;
        pop_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mcntl__tx__req_valid) begin
                    if (mcntl__tx__req_num_words == {LEN_W{1'b0}}) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = ST_SEND;
                        hdr_type_d  = mcntl__tx__req_type;
                        hdr_ptype_d = mcntl__tx__req_ptype;
                        hdr_mgr_d   = mcntl__tx__req_mgrId;
                        len_d       = (mcntl__tx__req_num_words > MAX_LEN) ?
                                      MAX_LEN : mcntl__tx__req_num_words;
                        rem_d       = len_d;
                        drop_d      = LOCAL_DROP_EN &
                                      (mcntl__tx__req_mgrId == sys__mgr__mgrId);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                // Dropped packets drain at full rate without waiting on the NoC.
                if (!fifo_empty_s && (ready_d1_q || drop_q)) begin
                    pop_s = 1'b1;
                    rem_d = rem_q - LEN_W'(1);
                    if (!drop_q) begin
                        valid_d = 1'b1;
                        // cntl[1] marks the last word, cntl[0] the first.
                        cntl_d  = {(rem_q == LEN_W'(1)), (rem_q == len_q)};
                        type_d  = hdr_type_q;
                        ptype_d = hdr_ptype_q;
                        mgr_d   = hdr_mgr_q;
                        data_d  = mem_q[rd_ptr_q];
                    end else begin
                        valid_d = 1'b0;
                    end
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        if (!drop_q) begin
                            pkt_count_d = pkt_count_q + PKT_CNT_WIDTH'(1);
                        end else begin
                            pkt_count_d = pkt_count_q;
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy next values
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            for (int i = 0; i < DATA_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= mcntl__tx__data;
        end
    end

    // State, header, FIFO bookkeeping and output registers
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state_q     <= ST_IDLE;
            ready_d1_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hdr_type_q  <= '0;
            hdr_ptype_q <= '0;
            hdr_mgr_q   <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            drop_q      <= 1'b0;
            valid_q     <= 1'b0;
            cntl_q      <= '0;
            type_q      <= '0;
            ptype_q     <= '0;
            data_q      <= '0;
            mgr_q       <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_d1_q  <= noc__mcntl__ready;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hdr_type_q  <= hdr_type_d;
            hdr_ptype_q <= hdr_ptype_d;
            hdr_mgr_q   <= hdr_mgr_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            drop_q      <= drop_d;
            valid_q     <= valid_d;
            cntl_q      <= cntl_d;
            type_q      <= type_d;
            ptype_q     <= ptype_d;
            data_q      <= data_d;
            mgr_q       <= mgr_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mcntl_noc_tx.sv
// Self-checking bench for mcntl_noc_tx. A queue-based packet model runs
// alongside the DUT and every output is compared on every falling edge;
// directed scenarios add literal expectations, then a randomized phase runs.
module tb_mcntl_noc_tx;

    localparam int DEPTH = 4;
    localparam int MAXW  = 16;
`ifdef MCNTL_NOC_TX_LOCAL_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_type;
    logic [1:0]  req_ptype;
    logic [3:0]  req_mgr;
    logic [4:0]  req_nw;
    logic        req_ready;
    logic        data_valid;
    logic [31:0] data_in;
    logic        data_ready;
    logic        noc_valid;
    logic [1:0]  noc_cntl;
    logic [2:0]  noc_type;
    logic [1:0]  noc_ptype;
    logic [31:0] noc_data;
    logic        noc_pvalid;
    logic [3:0]  noc_mgr;
    logic        noc_ready;
    logic [3:0]  sys_mgr;
    logic        busy;
    logic [15:0] pkt_count;
    logic        err;

    mcntl_noc_tx dut (
        .clk                      (clk),
        .reset_poweron_n          (rst_n),
        .mcntl__tx__req_valid     (req_valid),
        .mcntl__tx__req_type      (req_type),
        .mcntl__tx__req_ptype     (req_ptype),
        .mcntl__tx__req_mgrId     (req_mgr),
        .mcntl__tx__req_num_words (req_nw),
        .tx__mcntl__req_ready     (req_ready),
        .mcntl__tx__data_valid    (data_valid),
        .mcntl__tx__data          (data_in),
        .tx__mcntl__data_ready    (data_ready),
        .mcntl__noc__valid        (noc_valid),
        .mcntl__noc__cntl         (noc_cntl),
        .mcntl__noc__type         (noc_type),
        .mcntl__noc__ptype        (noc_ptype),
        .mcntl__noc__data         (noc_data),
        .mcntl__noc__pvalid       (noc_pvalid),
        .mcntl__noc__mgrId        (noc_mgr),
        .noc__mcntl__ready        (noc_ready),
        .sys__mgr__mgrId          (sys_mgr),
        .tx__mcntl__busy          (busy),
        .tx__mcntl__pkt_count     (pkt_count),
        .tx__mcntl__err_zero_len  (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] mq[$];
    bit        m_send, m_drop, m_rdy;
    int        m_rem, m_len;
    bit [2:0]  m_type;
    bit [1:0]  m_ptype;
    bit [3:0]  m_mgr;
    bit        e_valid, e_err;
    bit [1:0]  e_cntl;
    bit [2:0]  e_type;
    bit [1:0]  e_ptype;
    bit [3:0]  e_mgr;
    bit [31:0] e_data;
    bit [15:0] e_cnt;
    bit        rdy_prev1, rdy_prev2;

    always @(posedge clk) begin : model
        bit        push;
        bit [31:0] w;
        int        n;
        cyc++;
        rdy_prev2 = rdy_prev1;
        rdy_prev1 = noc_ready;
        if (!rst_n) begin
            mq.delete();
            m_send = 0; m_drop = 0; m_rdy = 0; m_rem = 0; m_len = 0;
            m_type = 0; m_ptype = 0; m_mgr = 0;
            e_valid = 0; e_err = 0; e_cntl = 0; e_type = 0; e_ptype = 0;
            e_mgr = 0; e_data = 0; e_cnt = 0;
        end else begin
            push    = data_valid && (mq.size() < DEPTH);
            e_err   = 0;
            e_valid = 0;
            if (!m_send) begin
                if (req_valid) begin
                    n = int'(req_nw);
                    if (n == 0) begin
                        e_err = 1;
                    end else begin
                        if (n > MAXW) n = MAXW;
                        m_len = n; m_rem = n;
                        m_type = req_type; m_ptype = req_ptype; m_mgr = req_mgr;
                        m_drop = DROP_EN && (req_mgr == sys_mgr);
                        m_send = 1;
                    end
                end
            end else if (mq.size() > 0 && (m_rdy || m_drop)) begin
                w = mq.pop_front();
                m_rem--;
                if (!m_drop) begin
                    e_valid = 1;
                    e_data  = w;
                    e_cntl  = {m_rem == 0, m_rem == m_len - 1};
                    e_type  = m_type; e_ptype = m_ptype; e_mgr = m_mgr;
                end
                if (m_rem == 0) begin
                    m_send = 0;
                    if (!m_drop) e_cnt++;
                end
            end
            if (push) mq.push_back(data_in);
            m_rdy = noc_ready;
        end
    end

    // ---------------- compare and monitor ----------------
    typedef struct {
        logic [31:0] data;
        logic [1:0]  cntl;
        logic [3:0]  mgr;
        logic [2:0]  typ;
        logic [1:0]  ptype;
        int          cyc;
    } ent_t;
    ent_t wlog[$];
    int   err_seen = 0;

    always @(negedge clk) begin
        chk("valid", noc_valid, e_valid);
        chk("pvalid", noc_pvalid, e_valid);
        chk("cntl", noc_cntl, e_cntl);
        chk("type", noc_type, e_type);
        chk("ptype", noc_ptype, e_ptype);
        chk("mgrId", noc_mgr, e_mgr);
        chk("data", noc_data, e_data);
        chk("pkt_count", pkt_count, e_cnt);
        chk("err_zero_len", err, e_err);
        chk("req_ready", req_ready, !m_send);
        chk("data_ready", data_ready, mq.size() != DEPTH);
        chk("busy", busy, m_send);
        if (noc_valid) begin
            chk("bp_window", rdy_prev2, 1'b1);
            wlog.push_back('{noc_data, noc_cntl, noc_mgr, noc_type, noc_ptype, cyc});
        end
        if (err) err_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [31:0] w);
        bit acc = 0;
        data_valid = 1'b1;
        data_in    = w;
        for (int k = 0; k < 3000; k++) begin
            acc = data_ready;
            @(negedge clk);
            if (acc) break;
        end
        data_valid = 1'b0;
        if (!acc) timeout("push");
    endtask

    task automatic request(input logic [2:0] t, input logic [1:0] p, input logic [3:0] m,
                           input logic [4:0] n, output int hs);
        bit acc = 0;
        hs        = -1;
        req_valid = 1'b1;
        req_type  = t; req_ptype = p; req_mgr = m; req_nw = n;
        for (int k = 0; k < 3000; k++) begin
            acc = req_ready;
            if (acc) hs = cyc;
            @(negedge clk);
            if (acc) break;
        end
        req_valid = 1'b0;
        if (!acc) timeout("request");
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy && !m_send) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_idle");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, pc, e0, d, cnt, total;
        bit stop;
        int lens[25];

        rst_n = 1'b0; req_valid = 1'b0; req_type = '0; req_ptype = '0; req_mgr = '0;
        req_nw = '0; data_valid = 1'b0; data_in = '0; noc_ready = 1'b1; sys_mgr = 4'd3;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1: three-word packet
        wlog.delete();
        push(32'hA1); push(32'hA2); push(32'hA3);
        request(3'd1, 2'd2, 4'd5, 5'd3, hs);
        wait_idle();
        chk("t1_len", wlog.size(), 32'd3);
        for (int i = 0; i < wlog.size() && i < 3; i++) begin
            chk("t1_data", wlog[i].data, 32'hA1 + i);
            chk("t1_mgr", wlog[i].mgr, 32'd5);
            chk("t1_type", wlog[i].typ, 32'd1);
            chk("t1_ptype", wlog[i].ptype, 32'd2);
        end
        if (wlog.size() == 3) begin
            chk("t1_som", wlog[0].cntl, 32'h1);
            chk("t1_mom", wlog[1].cntl, 32'h0);
            chk("t1_eom", wlog[2].cntl, 32'h2);
            chk("t1_latency", wlog[0].cyc, hs + 2);
            chk("t1_rate", wlog[2].cyc, hs + 4);
        end
        chk("t1_pkt_count", pkt_count, 32'd1);

        // 2: single-word packet
        wlog.delete();
        push(32'h55);
        request(3'd0, 2'd0, 4'd5, 5'd1, hs);
        wait_idle();
        chk("t2_len", wlog.size(), 32'd1);
        if (wlog.size() == 1) begin
            chk("t2_cntl", wlog[0].cntl, 32'h3);
            chk("t2_data", wlog[0].data, 32'h55);
        end
        chk("t2_pkt_count", pkt_count, 32'd2);

        // 3: eight-word packet with a 4-cycle NoC stall
        wlog.delete();
        d = 0;
        for (int i = 0; i < 4; i++) push(32'hB0 + i);
        fork
            request(3'd2, 2'd1, 4'd6, 5'd8, hs);
            begin for (int i = 4; i < 8; i++) push(32'hB0 + i); end
            begin
                repeat (4) @(negedge clk);
                noc_ready = 1'b0;
                d = cyc;
                repeat (4) @(negedge clk);
                noc_ready = 1'b1;
            end
        join
        wait_idle();
        chk("t3_len", wlog.size(), 32'd8);
        cnt = 0;
        for (int i = 0; i < wlog.size() && i < 8; i++) begin
            chk("t3_data", wlog[i].data, 32'hB0 + i);
            if (wlog[i].cyc >= d + 2 && wlog[i].cyc <= d + 5) cnt++;
        end
        chk("t3_stall_words", cnt, 32'd0);
        if (wlog.size() == 8) begin
            chk("t3_som", wlog[0].cntl, 32'h1);
            chk("t3_eom", wlog[7].cntl, 32'h2);
        end

        // 4: FIFO full, six words through a four-entry FIFO
        wlog.delete();
        for (int i = 0; i < 4; i++) push(32'hC0 + i);
        chk("t4_full", data_ready, 1'b0);
        fork
            request(3'd3, 2'd0, 4'd7, 5'd6, hs);
            begin push(32'hC4); push(32'hC5); end
        join
        wait_idle();
        chk("t4_len", wlog.size(), 32'd6);
        for (int i = 0; i < wlog.size() && i < 6; i++) chk("t4_data", wlog[i].data, 32'hC0 + i);

        // 5: zero-length request, then reset mid-packet
        wlog.delete();
        e0 = err_seen;
        pc = pkt_count;
        request(3'd1, 2'd1, 4'd5, 5'd0, hs);
        repeat (3) @(negedge clk);
        chk("t5_err_pulses", err_seen - e0, 32'd1);
        chk("t5_no_words", wlog.size(), 32'd0);
        chk("t5_pkt_count", pkt_count, pc);
        for (int i = 0; i < 4; i++) push(32'hD0 + i);
        request(3'd1, 2'd1, 4'd5, 5'd5, hs);
        cnt = 0;
        while (wlog.size() < 2 && cnt < 100) begin @(negedge clk); cnt++; end
        if (cnt >= 100) timeout("t5_wait");
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_valid", noc_valid, 1'b0);
        chk("t5_rst_cntl", noc_cntl, 32'd0);
        chk("t5_rst_data", noc_data, 32'd0);
        chk("t5_rst_mgr", noc_mgr, 32'd0);
        chk("t5_rst_count", pkt_count, 32'd0);
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_fifo_empty", data_ready, 1'b1);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 6: self-addressed packet
        wlog.delete();
        pc = pkt_count;
        push(32'hE0); push(32'hE1);
        request(3'd0, 2'd3, 4'd3, 5'd2, hs);
        wait_idle();
        if (DROP_EN) begin
            chk("t6_drop_no_words", wlog.size(), 32'd0);
            chk("t6_drop_count", pkt_count, pc);
            for (int i = 0; i < 4; i++) push(32'hF0 + i);
            chk("t6_drained", data_ready, 1'b0);
            request(3'd0, 2'd0, 4'd5, 5'd4, hs);
            wait_idle();
            chk("t6_next_len", wlog.size(), 32'd4);
            if (wlog.size() > 0) chk("t6_next_first", wlog[0].data, 32'hF0);
        end else begin
            chk("t6_len", wlog.size(), 32'd2);
            for (int i = 0; i < wlog.size() && i < 2; i++) begin
                chk("t6_mgr", wlog[i].mgr, 32'd3);
                chk("t6_data", wlog[i].data, 32'hE0 + i);
            end
            chk("t6_count", pkt_count, pc + 1);
        end

        // Randomized traffic with random back-pressure
        total = 0;
        for (int i = 0; i < 25; i++) begin
            lens[i] = $urandom_range(0, 20);
            total += (lens[i] > MAXW) ? MAXW : lens[i];
        end
        stop = 0;
        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 25; i++)
                            request(3'($urandom), 2'($urandom), 4'($urandom_range(0, 15)),
                                    5'(lens[i]), hs);
                    end
                    begin for (int i = 0; i < total; i++) push($urandom); end
                join
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(negedge clk);
                    noc_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        noc_ready = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcntl_noc_tx.md
Name: mcntl_noc_tx

Overview:
- Transmit-side packetizer for the manager controller: builds NoC packets from a header request plus a data-word stream and drives them onto the manager NoC port.
- Return-direction counterpart of the NoC→manager-controller receive path.
- Sits between manager-controller logic (status, responses, host replies) and the NoC controller input.
- Frames each packet with cntl SOM/MOM/EOM and honours registered NoC back-pressure.

Parameters:
- DATA_FIFO_DEPTH, 4: data-word FIFO entries, power of 2, minimum 2.
- MAX_PKT_WORDS, 16: maximum words per packet. Length field width is clog2(MAX_PKT_WORDS)+1.
- PKT_CNT_WIDTH, 16: width of the sent-packet counter.

Ports:
- clk  in  1  clock
- reset_poweron_n  in  1  reset, asynchronous, active-low
- mcntl__tx__req_valid  in  1  header request valid
- mcntl__tx__req_type  in  `MGR_NOC_CONT_NOC_PACKET_TYPE_RANGE  packet type
- mcntl__tx__req_ptype  in  `MGR_NOC_CONT_NOC_PAYLOAD_TYPE_RANGE  payload type
- mcntl__tx__req_mgrId  in  `MGR_MGR_ID_RANGE  destination manager
- mcntl__tx__req_num_words  in  clog2(MAX_PKT_WORDS)+1  words in packet
- tx__mcntl__req_ready  out  1  header accepted when valid&ready
- mcntl__tx__data_valid  in  1  data word valid
- mcntl__tx__data  in  `MGR_NOC_CONT_INTERNAL_DATA_RANGE  data word
- tx__mcntl__data_ready  out  1  FIFO not full
- mcntl__noc__valid  out  1  NoC word valid
- mcntl__noc__cntl  out  `COMMON_STD_INTF_CNTL_RANGE  framing
- mcntl__noc__type  out  packet-type range  packet type
- mcntl__noc__ptype  out  payload-type range  payload type
- mcntl__noc__data  out  internal-data range  payload word
- mcntl__noc__pvalid  out  1  payload valid
- mcntl__noc__mgrId  out  `MGR_MGR_ID_RANGE  destination
- noc__mcntl__ready  in  1  NoC can accept
- sys__mgr__mgrId  in  `MGR_MGR_ID_RANGE  own manager ID
- tx__mcntl__busy  out  1  packet in progress
- tx__mcntl__pkt_count  out  PKT_CNT_WIDTH  packets completed
- tx__mcntl__err_zero_len  out  1  one-cycle pulse on a zero-length request

Behaviour:

Reset and back-pressure
- Reset value of every output and internal register is 0. This includes the FSM (IDLE), the FIFO pointers and count, and ready_d1.
- Asserting reset mid-packet abandons the packet; the NoC side discards any unterminated packet.
- noc__mcntl__ready is registered into ready_d1. A word is launched only in a cycle where ready_d1=1.
- After deasserting ready, the NoC absorbs up to 2 further words.

Data FIFO
- tx__mcntl__data_ready = (count != DATA_FIFO_DEPTH), combinational from the registered count.
- Write when data_valid & data_ready. Writes are accepted in any FSM state.
- A simultaneous push and pop leaves the count unchanged; at full, a simultaneous pop does not enable a push in the same cycle.
- Pointers wrap modulo DATA_FIFO_DEPTH.
- Words beyond the current packet length stay queued for the next packet.

FSM IDLE/SEND
- IDLE: req_ready=1. On the handshake, latch type/ptype/mgrId/num_words into the header registers and set remaining=num_words.
- num_words=0: remain in IDLE and pulse err_zero_len for 1 cycle.
- num_words>MAX_PKT_WORDS: clamp to MAX_PKT_WORDS.
- SEND: req_ready=0, busy=1.
- Launch a word when ready_d1 & FIFO not empty: pop the FIFO, decrement remaining, register the outputs with valid=1 and pvalid=1.
- cntl framing:
  - first word of a multi-word packet = SOM 2'b01
  - middle words = MOM 2'b00
  - last word = EOM 2'b10
  - a single-word packet = SOM_EOM 2'b11
- On the last-word launch: return to IDLE and increment pkt_count, which wraps at all-ones to 0.
- When no launch occurs: valid=0 and pvalid=0; type/ptype/mgrId/data/cntl hold their last values.

Latency and throughput
- Handshake in cycle 0 → SEND in cycle 1 → first word visible in cycle 2, provided the FIFO is non-empty and ready_d1=1 in cycle 1.
- Steady state: 1 word/cycle.
- A back-to-back packet: the next request is accepted in the cycle after the EOM launch, giving a 1-cycle gap.

Optional Feature:
- Macro: MCNTL_NOC_TX_LOCAL_DROP_EN.
- Enabled: a request whose req_mgrId == sys__mgr__mgrId is still accepted. Its num_words FIFO words are popped at 1 per cycle, regardless of ready_d1, with valid held at 0. pkt_count is not incremented.
- Disabled: self-addressed packets are transmitted normally.

Test Plan:
1. Reset, push 3 words (0xA1, 0xA2, 0xA3), request type=1, ptype=2, mgrId=5, num_words=3, ready=1 → words on cycles 2–4 with cntl 01/00/10, mgrId=5, pkt_count=1.
2. Single-word request (num_words=1, data 0x55) → one word with cntl=11, valid high for 1 cycle, busy drops the next cycle.
3. 8-word packet, drop noc ready for 4 cycles mid-packet → at most 2 words after the drop, valid=0 otherwise, data held, ordering intact, EOM on word 8.
4. Push 6 words with DATA_FIFO_DEPTH=4 → data_ready=0 after 4 words; with a simultaneous push and pop at count 4 the push is rejected; all 6 words are eventually sent in order.
5. num_words=0 request → err_zero_len pulses for 1 cycle, no NoC activity, pkt_count unchanged; reset asserted mid 5-word packet → all outputs 0 and FIFO empty.
6. With MCNTL_NOC_TX_LOCAL_DROP_EN, request mgrId == sys__mgr__mgrId (=3) with 2 words → no valid, FIFO drained, pkt_count unchanged; without the macro → 2 words transmitted with mgrId=3.
